// File: rtl/mmio_fifo_port.sv
// rtl/mmio_fifo_port.sv - memory-mapped 16-bit push FIFO with valid/ready drain port
// Optional low-water interrupt and THRESH register under MMIO_FIFO_IRQ_EN.
module mmio_fifo_port #(
  parameter logic [3:0] BASE  = 4'h3,
  parameter int         DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  output logic        Sel,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
`ifdef MMIO_FIFO_IRQ_EN
  ,
  output logic        Irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [15:0]   ram_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   ovf_q, ovf_d;
  logic [15:0]   din_q, din_d;
  logic          sel_q;

  logic       hit;
  logic [1:0] off;
  logic       full, empty;
  logic       push_req, push, pop, drop, flush;
  logic [7:0] thresh_rd;

  logic unused_addr;
  assign unused_addr = ^ADDR[11:2];

  assign hit       = (ADDR[15:12] == BASE);
  assign off       = ADDR[1:0];
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign out_valid = ~empty;
  assign out_data  = empty ? 16'h0000 : ram_q[rd_ptr_q];
  assign push_req  = W & hit & (off == 2'd0);
  assign flush     = W & hit & (off == 2'd2);
  assign pop       = out_valid & out_ready;
  // A push into a full FIFO still lands when the consumer frees a slot this cycle.
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

`ifdef MMIO_FIFO_IRQ_EN
  logic [7:0] thresh_q, thresh_d;
  logic       irq_q;

  always_comb begin
    thresh_d = thresh_q;
    if (W && hit && (off == 2'd3)) begin
      thresh_d = DOUT[7:0];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      thresh_q <= 8'h00;
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= (8'(count_q) <= thresh_q);
    end
  end

  assign thresh_rd = thresh_q;
  assign Irq       = irq_q;
`else
  assign thresh_rd = 8'h00;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      // Flush beats a simultaneous pop; the popped word is simply gone.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 16'h0000;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (drop && (ovf_q != 16'hFFFF)) begin
        ovf_d = ovf_q + 16'd1;
      end
    end
  end

  always_comb begin
    din_d = 16'h0000;
    if (hit) begin
      case (off)
        2'd0:    din_d = out_data;
        2'd1:    din_d = {full, empty, 6'b000000, 8'(count_q)};
        2'd2:    din_d = ovf_q;
        default: din_d = {8'h00, thresh_rd};
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 16'h0000;
      din_q    <= 16'h0000;
      sel_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      din_q    <= din_d;
      sel_q    <= hit;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      ram_q[wr_ptr_q] <= DOUT;
    end
  end

  assign DIN = din_q;
  assign Sel = sel_q;

endmodule
